// File: rtl/hex_ascii_pkg.sv
// Shared definitions for the ASCII text emitters.
//   ASCII_*    : character codes used when printing hex words
//   tx_state_e : state encoding of the word-to-text emitter FSM
package hex_ascii_pkg;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_X  = 8'h78;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PFX0,
    ST_PFX1,
    ST_DIG,
    ST_CR,
    ST_LF
  } tx_state_e;

endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational single-nibble to ASCII hex digit converter.
//   in    : 4-bit nibble
//   lower : 1 = 'a'-'f', 0 = 'A'-'F'
//   out   : ASCII code of the digit
module hex_nibble_ascii
  import hex_ascii_pkg::*;
(
  input  logic [3:0] in,
  input  logic       lower,
  output logic [7:0] out
);

  always_comb begin
    if (in < 4'd10) begin
      out = ASCII_0 + {4'h0, in};
    end else begin
      out = (lower ? ASCII_LA : ASCII_UA) + {4'h0, in} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_word_to_ascii_tx.sv
// Streams a DATA_W-bit value as ASCII hex text, one character per handshake,
// with optional "0x" prefix, optional CR/LF terminator, selectable digit case
// and leading-zero suppression.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : value handshake (in_data, in_lower, in_zsup sampled at accept)
//   out_valid/out_ready   : character handshake (out_char, out_last)
//   busy                  : word accepted and not yet fully emitted
module hex_word_to_ascii_tx
  import hex_ascii_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PREFIX_EN = 1,
  parameter int TERM_EN   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_lower,
  input  logic              in_zsup,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              out_last,
  output logic              busy
);

  localparam int NIB   = DATA_W / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  tx_state_e         state, state_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              lower_q, lower_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt, lz_idx;
  logic              accept, hs;
  logic [3:0]        nib_sel;
  logic [7:0]        nib_char;
  logic [7:0]        char_nxt;
  logic              valid_nxt, last_nxt, ready_nxt, busy_nxt;

  assign accept = in_valid & in_ready;
  assign hs     = out_valid & out_ready;

  // Highest nonzero nibble of the offered value; 0 when the value is zero,
  // so a zero word still prints a single '0'.
  always_comb begin
    lz_idx = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (in_data[4*i +: 4] != 4'h0) lz_idx = IDX_W'(i);
    end
  end

  // Next-state logic, including capture register and digit counter.
  always_comb begin
    state_nxt = state;
    data_nxt  = data_q;
    lower_nxt = lower_q;
    idx_nxt   = idx;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          data_nxt  = in_data;
          lower_nxt = in_lower;
          idx_nxt   = in_zsup ? lz_idx : IDX_W'(NIB - 1);
          state_nxt = (PREFIX_EN != 0) ? ST_PFX0 : ST_DIG;
        end
      end
      ST_PFX0: if (hs) state_nxt = ST_PFX1;
      ST_PFX1: if (hs) state_nxt = ST_DIG;
      ST_DIG: begin
        if (hs) begin
          if (idx == '0) begin
            state_nxt = (TERM_EN != 0) ? ST_CR : ST_IDLE;
          end else begin
            idx_nxt = idx - IDX_W'(1);
          end
        end
      end
      ST_CR:   if (hs) state_nxt = ST_LF;
      ST_LF:   if (hs) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered, so the character is derived from the next state
  // and next digit index; while stalled these equal the current ones and the
  // registered character stays put.
  assign nib_sel = 4'(data_nxt >> {idx_nxt, 2'b00});

  hex_nibble_ascii u_nib (
    .in    (nib_sel),
    .lower (lower_nxt),
    .out   (nib_char)
  );

  always_comb begin
    valid_nxt = (state_nxt != ST_IDLE);
    busy_nxt  = (state_nxt != ST_IDLE);
    ready_nxt = (state_nxt == ST_IDLE);
    char_nxt  = out_char;
    last_nxt  = 1'b0;
    case (state_nxt)
      ST_PFX0: char_nxt = ASCII_0;
      ST_PFX1: char_nxt = ASCII_X;
      ST_DIG: begin
        char_nxt = nib_char;
        last_nxt = (TERM_EN == 0) && (idx_nxt == '0);
      end
      ST_CR:   char_nxt = ASCII_CR;
      ST_LF: begin
        char_nxt = ASCII_LF;
        last_nxt = 1'b1;
      end
      default: char_nxt = out_char;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      data_q    <= '0;
      lower_q   <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      out_last  <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      data_q    <= data_nxt;
      lower_q   <= lower_nxt;
      idx       <= idx_nxt;
      out_valid <= valid_nxt;
      out_char  <= char_nxt;
      out_last  <= last_nxt;
      in_ready  <= ready_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_hex_word_to_ascii_tx.sv
module tb_hex_word_to_ascii_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel, iv, ilow, izs, ordy;
  logic [15:0] idata;

  logic        ir16, ov16, ol16, bz16;
  logic [7:0]  oc16;
  logic        ir8, ov8, ol8, bz8;
  logic [7:0]  oc8;

  logic        ir, ov, ol, bz;
  logic [7:0]  oc;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  hex_word_to_ascii_tx #(.DATA_W(16), .PREFIX_EN(1), .TERM_EN(1)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv & ~sel),
    .in_ready  (ir16),
    .in_data   (idata),
    .in_lower  (ilow),
    .in_zsup   (izs),
    .out_valid (ov16),
    .out_ready (ordy),
    .out_char  (oc16),
    .out_last  (ol16),
    .busy      (bz16)
  );

  hex_word_to_ascii_tx #(.DATA_W(8), .PREFIX_EN(0), .TERM_EN(0)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv & sel),
    .in_ready  (ir8),
    .in_data   (idata[7:0]),
    .in_lower  (ilow),
    .in_zsup   (izs),
    .out_valid (ov8),
    .out_ready (ordy),
    .out_char  (oc8),
    .out_last  (ol8),
    .busy      (bz8)
  );

  assign ir = sel ? ir8 : ir16;
  assign ov = sel ? ov8 : ov16;
  assign ol = sel ? ol8 : ol16;
  assign bz = sel ? bz8 : bz16;
  assign oc = sel ? oc8 : oc16;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // Expected text of one word: optional prefix, significant digits, optional terminator.
  function automatic void build_model(input logic s, input logic [15:0] v,
                                      input logic lo, input logic zs);
    int nib = s ? 2 : 4;
    int nd  = nib;
    int d;
    exp_q.delete();
    if (!s) begin
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h78);
    end
    if (zs) begin
      while (nd > 1 && ((int'(v) >> (4 * (nd - 1))) % 16) == 0) nd--;
    end
    for (int i = nd - 1; i >= 0; i--) begin
      d = (int'(v) >> (4 * i)) % 16;
      if (d < 10) exp_q.push_back(8'(48 + d));
      else        exp_q.push_back(8'((lo ? 97 : 65) + d - 10));
    end
    if (!s) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  // mode 0: out_ready tied high; 1: random backpressure; 2: stall 3 cycles on first 0x45.
  // Called and returns at a negedge.
  task automatic run_word(input logic s, input logic [15:0] v, input logic lo,
                          input logic zs, input int mode, input bit hold);
    int   t, k, stalls;
    bit   prev_st, stall_done, r;
    logic [7:0] held;
    build_model(s, v, lo, zs);
    sel = s;
    t = 0;
    while (!ir && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ir) begin
      check("accept_wait", 32'(ir), 32'd1);
      return;
    end
    iv = 1'b1; idata = v; ilow = lo; izs = zs;
    @(negedge clk);
    if (!hold) begin
      iv = 1'b0; idata = 16'($urandom); ilow = 1'($urandom); izs = 1'($urandom);
    end
    check("busy_rise", 32'(bz), 32'd1);
    check("ready_drop", 32'(ir), 32'd0);
    check("first_valid", 32'(ov), 32'd1);
    k = 0; t = 0; stalls = 0; stall_done = 0; prev_st = 0; held = 8'h00;
    while (k < exp_q.size() && t < 400) begin
      if (prev_st) begin
        check("stall_char", 32'(oc), 32'(held));
        check("stall_valid", 32'(ov), 32'd1);
      end
      if (mode == 0) check("tput_valid", 32'(ov), 32'd1);
      if (hold) check("no_reaccept", 32'(ir), 32'd0);
      case (mode)
        0: r = 1'b1;
        1: r = ($urandom_range(0, 3) != 0);
        default: begin
          if (ov && oc == 8'h45 && !stall_done) begin
            if (stalls < 3) begin
              r = 1'b0;
              stalls++;
            end else begin
              r = 1'b1;
              stall_done = 1'b1;
            end
          end else begin
            r = 1'b1;
          end
        end
      endcase
      ordy = r;
      if (ov && r) begin
        check("char", 32'(oc), 32'(exp_q[k]));
        check("last", 32'(ol), 32'(k == exp_q.size() - 1));
        k++;
      end
      prev_st = ov && !r;
      held = oc;
      @(negedge clk);
      t++;
    end
    if (k < exp_q.size()) check("word_timeout", 32'(k), 32'(exp_q.size()));
    check("end_valid", 32'(ov), 32'd0);
    check("end_ready", 32'(ir), 32'd1);
    check("end_busy", 32'(bz), 32'd0);
    if (mode == 2) check("stall_seen", 32'(stalls), 32'd3);
    ordy = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s, lo, zs;
    logic [15:0] v;
    sel = 1'b0; iv = 1'b0; idata = '0; ilow = 1'b0; izs = 1'b0; ordy = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(ov16), 32'd0);
    check("rst_char", 32'(oc16), 32'h00);
    check("rst_last", 32'(ol16), 32'd0);
    check("rst_busy", 32'(bz16), 32'd0);
    check("rst_ready16", 32'(ir16), 32'd0);
    check("rst_ready8", 32'(ir8), 32'd0);
    rst_n = 1'b1;
    check("rel_ready_low", 32'(ir16), 32'd0);
    @(negedge clk);
    check("rel_ready_up", 32'(ir16), 32'd1);
    ordy = 1'b1;

    run_word(1'b0, 16'hBEEF, 1'b0, 1'b0, 0, 1'b0);
    run_word(1'b0, 16'hBEEF, 1'b1, 1'b0, 0, 1'b0);
    run_word(1'b0, 16'h00A5, 1'b0, 1'b1, 0, 1'b0);
    run_word(1'b0, 16'h0000, 1'b0, 1'b1, 0, 1'b0);
    run_word(1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
    run_word(1'b0, 16'hBEEF, 1'b0, 1'b0, 2, 1'b0);

    // Reset in the middle of the digits
    sel = 1'b0; iv = 1'b1; idata = 16'hBEEF; ilow = 1'b0; izs = 1'b0; ordy = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_char", 32'(oc16), 32'h45);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ov16), 32'd0);
    check("mid_rst_busy", 32'(bz16), 32'd0);
    check("mid_rst_ready", 32'(ir16), 32'd0);
    check("mid_rst_char", 32'(oc16), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rel_low", 32'(ir16), 32'd0);
    @(negedge clk);
    check("mid_rel_up", 32'(ir16), 32'd1);
    run_word(1'b0, 16'h1234, 1'b0, 1'b0, 0, 1'b0);

    // 8-bit, no prefix/terminator, in_valid held high across the word
    run_word(1'b1, 16'h007C, 1'b0, 1'b0, 0, 1'b1);
    run_word(1'b1, 16'h007C, 1'b0, 1'b0, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      s  = 1'($urandom);
      v  = 16'($urandom) >> $urandom_range(0, 15);
      if (s) v = v & 16'h00FF;
      lo = 1'($urandom);
      zs = 1'($urandom);
      run_word(s, v, lo, zs, 1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
